// File: rtl/seg_scan.sv
// seg_scan: six-digit multiplexed seven-segment scanner for a common-anode HH:MM:SS display.
// Latency: sel/seg are registered, 1 clk behind the internal digit index; each digit is held SCAN_DIV cycles.
// Backpressure: none; the time inputs are sampled once per frame and changes between snapshots are ignored.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   hr, mn, sd        packed-BCD hours/minutes/seconds (tens in [7:4], units in [3:0])
//   sel[5:0]          active-low one-cold digit enables, digit 0 = leftmost (hours tens)
//   seg[7:0]          active-low segments, [7]=dp (colon), [6:0]=gfedcba
//   frame_done        one-cycle pulse on the edge where the frame wraps and a new snapshot is taken
//
// Optional build macro SEG_SCAN_LZB_EN: blank digit 0 when the snapshot hours tens nibble is zero.
module seg_scan #(
  parameter logic [15:0] SCAN_DIV = 16'd50_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] hr,
  input  logic [7:0] mn,
  input  logic [7:0] sd,
  output logic [5:0] sel,
  output logic [7:0] seg,
  output logic       frame_done
);

  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  snap_hr;
  logic [7:0]  snap_mn;
  logic [7:0]  snap_sd;

  logic        tick;
  logic        frame_wrap;
  logic [3:0]  nib;
  logic [6:0]  seg7;
  logic        dp_n;
  logic        blank;
  logic [5:0]  sel_nxt;
  logic [7:0]  seg_nxt;

  assign tick       = (cnt == SCAN_DIV - 16'd1);
  assign frame_wrap = tick && (idx == 3'd5);

  // BCD to active-low gfedcba; anything above 9 shows a dash (segment g only).
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd_to_seg = 7'h40;
      4'd1:    bcd_to_seg = 7'h79;
      4'd2:    bcd_to_seg = 7'h24;
      4'd3:    bcd_to_seg = 7'h30;
      4'd4:    bcd_to_seg = 7'h19;
      4'd5:    bcd_to_seg = 7'h12;
      4'd6:    bcd_to_seg = 7'h02;
      4'd7:    bcd_to_seg = 7'h78;
      4'd8:    bcd_to_seg = 7'h00;
      4'd9:    bcd_to_seg = 7'h10;
      default: bcd_to_seg = 7'h3F;
    endcase
  endfunction

  always_comb begin
    nib = 4'h0;
    case (idx)
      3'd0:    nib = snap_hr[7:4];
      3'd1:    nib = snap_hr[3:0];
      3'd2:    nib = snap_mn[7:4];
      3'd3:    nib = snap_mn[3:0];
      3'd4:    nib = snap_sd[7:4];
      3'd5:    nib = snap_sd[3:0];
      default: nib = 4'h0;
    endcase
  end

  assign seg7 = bcd_to_seg(nib);

  // Colon dots sit after the hours units and minutes units digits; lit on even seconds.
  assign dp_n = !(((idx == 3'd1) || (idx == 3'd3)) && !snap_sd[0]);

`ifdef SEG_SCAN_LZB_EN
  assign blank = (idx == 3'd0) && (snap_hr[7:4] == 4'h0);
`else
  assign blank = 1'b0;
`endif

  assign sel_nxt = ~(6'b000001 << idx);
  assign seg_nxt = blank ? 8'hFF : {dp_n, seg7};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 16'd0;
      idx        <= 3'd0;
      snap_hr    <= 8'h00;
      snap_mn    <= 8'h00;
      snap_sd    <= 8'h00;
      sel        <= 6'b111111;
      seg        <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      cnt <= tick ? 16'd0 : cnt + 16'd1;
      if (tick) begin
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end
      // Snapshot only at the frame wrap so a digit never mixes two different times.
      if (frame_wrap) begin
        snap_hr <= hr;
        snap_mn <= mn;
        snap_sd <= sd;
      end
      frame_done <= frame_wrap;
      sel        <= sel_nxt;
      seg        <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed bench for seg_scan with SCAN_DIV=4 (24-cycle frames).
// Edges are counted from reset release; outputs are sampled 1 time unit after each rising edge.
module tb_seg_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] hr = 8'h12;
  logic [7:0] mn = 8'h34;
  logic [7:0] sd = 8'h56;
  logic [5:0] sel;
  logic [7:0] seg;
  logic       frame_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Hours tens digit of snapshot 00 or 09: blanked when leading-zero blanking is built in.
`ifdef SEG_SCAN_LZB_EN
  localparam logic [7:0] LEAD0 = 8'hFF;
`else
  localparam logic [7:0] LEAD0 = 8'hC0;
`endif

  seg_scan #(.SCAN_DIV(16'd4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hr         (hr),
    .mn         (mn),
    .sd         (sd),
    .sel        (sel),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int k);
    while (cyc < k) step();
  endtask

  logic [7:0] frame0 [6];
  logic [7:0] frame1 [6];

  initial begin
    int         i;
    logic [5:0] es;
    logic [7:0] eseg;

    // Snapshot 00:00:00, even seconds -> colon on idx1/idx3.
    frame0[0] = LEAD0; frame0[1] = 8'h40; frame0[2] = 8'hC0;
    frame0[3] = 8'h40; frame0[4] = 8'hC0; frame0[5] = 8'hC0;
    // Snapshot 12:34:56.
    frame1[0] = 8'hF9; frame1[1] = 8'h24; frame1[2] = 8'hB0;
    frame1[3] = 8'h19; frame1[4] = 8'h92; frame1[5] = 8'h82;

    // Reset held across several edges.
    repeat (3) @(posedge clk);
    #1;
    check("rst_sel", sel, 6'h3F);
    check("rst_seg", seg, 8'hFF);
    check("rst_fd", frame_done, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    step();
    check("first_sel", sel, 6'b111110);
    check("first_seg", seg, LEAD0);
    check("first_fd", frame_done, 1'b0);

    // Two full frames, every edge: digit hold, scan order, decode, colon, frame_done period.
    for (int k = 2; k <= 48; k++) begin
      step();
      i    = ((k - 1) / 4) % 6;
      es   = ~(6'b000001 << i);
      eseg = (k <= 24) ? frame0[i] : frame1[i];
      check("scan_sel", sel, es);
      check("scan_seg", seg, eseg);
      check("scan_fd", frame_done, (k % 24) == 0);
    end

    // Snapshot isolation: change minutes while idx2 is on screen in frame 3.
    step_to(57);
    check("iso_sel_idx2", sel, 6'b111011);
    mn = 8'h35;
    step_to(61);
    check("iso_sel_idx3", sel, 6'b110111);
    check("iso_old_min", seg, 8'h19);
    step_to(72);
    check("iso_fd", frame_done, 1'b1);
    step_to(85);
    check("iso_new_min", seg, 8'h12);

    // Seconds change in the very cycle of the snapshot tick is captured at that edge.
    step_to(95);
    check("pre_wrap_fd", frame_done, 1'b0);
    sd = 8'h3A;
    step_to(96);
    check("wrap_fd", frame_done, 1'b1);
    step_to(101);
    check("bad_colon_idx1", seg, 8'h24);
    step_to(109);
    check("bad_colon_idx3", seg, 8'h12);
    step_to(117);
    check("bad_bcd_sel", sel, 6'b011111);
    check("bad_bcd_seg", seg, 8'hBF);

    // Leading-zero hours: captured at edge 120, shown from edge 121.
    hr = 8'h09;
    step_to(121);
    check("lzb_sel", sel, 6'b111110);
    check("lzb_seg", seg, LEAD0);
    step_to(125);
    check("lzb_units", seg, 8'h10);

    // Reset mid-scan: after edge 134 the internal state is idx3, cnt2.
    step_to(134);
    rst_n = 1'b0;
    #2;
    check("mid_rst_sel", sel, 6'h3F);
    check("mid_rst_seg", seg, 8'hFF);
    check("mid_rst_fd", frame_done, 1'b0);
    @(negedge clk);
    check("mid_rst_hold_sel", sel, 6'h3F);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    step();
    check("restart_sel", sel, 6'b111110);
    check("restart_seg", seg, LEAD0);
    step_to(5);
    check("restart_idx1", seg, 8'h40);
    step_to(23);
    check("restart_no_fd", frame_done, 1'b0);
    step_to(24);
    check("restart_fd", frame_done, 1'b1);
    step_to(25);
    check("restart_snap_sel", sel, 6'b111110);
    check("restart_snap_seg", seg, LEAD0);
    step_to(29);
    check("restart_snap_idx1", seg, 8'h10);
    step_to(41);
    check("restart_snap_idx4", seg, 8'hB0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
